// File: rtl/lea_pkg.sv
// rtl/lea_pkg.sv - shared types and constants for the LEA controller
// Purpose: sequencer state encoding, address/counter widths and the
//          key-length to round-count mapping.
// Contents: state_t, RK_ADDR_W, CNT_W, nr_of()
package lea_pkg;

  localparam int RK_ADDR_W = 5;
  localparam int CNT_W     = 6;

  typedef enum logic [2:0] {
    IDLE,
    KS_RESET,
    KS_RUN,
    READY,
    ROUND,
    OUT
  } state_t;

  // Round count for a key length; unsupported lengths fall back to 128-bit.
  function automatic int nr_of(input int key_len);
    case (key_len)
      192:     return 28;
      256:     return 32;
      default: return 24;
    endcase
  endfunction

endpackage

// File: rtl/lea_controller_if.sv
// rtl/lea_controller_if.sv - control/handshake bundle around the LEA sequencer
// Purpose: groups key-schedule control, round-key RAM arbitration, datapath
//          strobes and the input/output valid/ready handshakes.
// Modports: master = lea_controller side, slave = bus wrapper / datapath side.
// Optional: LEA_DECRYPT_EN adds decrypt (block direction, sampled at accept).
interface lea_controller_if;
  import lea_pkg::*;

  logic                 key_load;
  logic                 key_ready;
  logic                 ks_rst;
  logic                 ks_done;
  logic                 rk_sel;
  logic [RK_ADDR_W-1:0] rk_addr;
  logic                 data_valid;
  logic                 data_ready;
  logic                 load_state;
  logic                 round_en;
  logic                 out_valid;
  logic                 out_ready;
  logic                 busy;
`ifdef LEA_DECRYPT_EN
  logic                 decrypt;
`endif

  modport master (
`ifdef LEA_DECRYPT_EN
    input  decrypt,
`endif
    input  key_load, ks_done, data_valid, out_ready,
    output key_ready, ks_rst, rk_sel, rk_addr, data_ready,
    output load_state, round_en, out_valid, busy
  );

  modport slave (
`ifdef LEA_DECRYPT_EN
    output decrypt,
`endif
    output key_load, ks_done, data_valid, out_ready,
    input  key_ready, ks_rst, rk_sel, rk_addr, data_ready,
    input  load_state, round_en, out_valid, busy
  );

endinterface

// File: rtl/counter.sv
// rtl/counter.sv - loadable up/down counter
// Purpose: general counter; used as the LEA round / round-key address counter.
// Ports: clk, rst (async, active-high), clr (sync clear), load + load_val,
//        up, down (clr > load > up > down), count.
module counter #(
  parameter int DATA_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_val,
  input  logic                  up,
  input  logic                  down,
  output logic [DATA_WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (up) begin
      count <= count + 1'b1;
    end else if (down) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/lea_controller.sv
// rtl/lea_controller.sv - LEA core sequencer
// Purpose: starts/monitors the key schedule, arbitrates the round-key RAM
//          between schedule writes and datapath reads, and runs one block
//          through NR rounds between input and output valid/ready handshakes.
// Ports: clk, rst (async, active-high), bus (lea_controller_if.master).
// Parameter: KEY_LEN 128/192/256 -> NR 24/28/32 (others -> 24).
// Optional: LEA_DECRYPT_EN - bus.decrypt sampled at accept; when set the
//           round-key address runs NR-1 down to 0. Timing is unchanged.
module lea_controller
  import lea_pkg::*;
#(
  parameter int KEY_LEN = 128
) (
  input logic              clk,
  input logic              rst,
  lea_controller_if.master bus
);

  localparam int               NR      = nr_of(KEY_LEN);
  localparam logic [CNT_W-1:0] LAST_UP = CNT_W'(NR - 1);

  state_t           state;
  state_t           state_nxt;
  logic             pending;
  logic             key_ready_q;
  logic             accept;
  logic             last_round;
  logic             dir_down;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] cnt_init;
  logic             cnt_clr;
  logic             cnt_up;
  logic             cnt_down;

`ifdef LEA_DECRYPT_EN
  // Direction is captured with the block so it cannot change mid-flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_down <= 1'b0;
    end else if (accept) begin
      dir_down <= bus.decrypt;
    end
  end
  assign cnt_init = bus.decrypt ? LAST_UP : '0;
`else
  assign dir_down = 1'b0;
  assign cnt_init = '0;
`endif

  assign last_round = dir_down ? (count == '0) : (count == LAST_UP);

  assign cnt_clr  = (state == KS_RESET);
  assign cnt_up   = (state == ROUND) && !last_round && !dir_down;
  assign cnt_down = (state == ROUND) && !last_round && dir_down;

  counter #(
    .DATA_WIDTH(CNT_W)
  ) u_round_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .load     (accept),
    .load_val (cnt_init),
    .up       (cnt_up),
    .down     (cnt_down),
    .count    (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pending     <= 1'b0;
      key_ready_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt == KS_RESET) begin
        pending     <= 1'b0;
        key_ready_q <= 1'b0;
      end else begin
        // A key change during a block is deferred until the result is taken.
        if ((state == ROUND || state == OUT) && bus.key_load) begin
          pending <= 1'b1;
        end
        if (state == KS_RUN && state_nxt == READY) begin
          key_ready_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    accept         = 1'b0;
    bus.ks_rst     = 1'b0;
    bus.rk_sel     = 1'b0;
    bus.data_ready = 1'b0;
    bus.load_state = 1'b0;
    bus.round_en   = 1'b0;
    bus.out_valid  = 1'b0;
    unique case (state)
      IDLE: begin
        bus.ks_rst = 1'b1;
        if (bus.key_load) begin
          state_nxt = KS_RESET;
        end
      end
      KS_RESET: begin
        bus.ks_rst = 1'b1;
        state_nxt  = KS_RUN;
      end
      KS_RUN: begin
        if (bus.key_load) begin
          state_nxt = KS_RESET;
        end else if (bus.ks_done) begin
          state_nxt = READY;
        end
      end
      READY: begin
        bus.rk_sel = 1'b1;
        // data_ready drops under key_load so a handshake always means accept.
        if (bus.key_load) begin
          state_nxt = KS_RESET;
        end else begin
          bus.data_ready = 1'b1;
          if (bus.data_valid) begin
            accept         = 1'b1;
            bus.load_state = 1'b1;
            state_nxt      = ROUND;
          end
        end
      end
      ROUND: begin
        bus.rk_sel   = 1'b1;
        bus.round_en = 1'b1;
        if (last_round) begin
          state_nxt = OUT;
        end
      end
      OUT: begin
        bus.rk_sel    = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_nxt = (pending || bus.key_load) ? KS_RESET : READY;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.key_ready = key_ready_q;
  assign bus.rk_addr   = count[RK_ADDR_W-1:0];
  assign bus.busy      = (state != IDLE) && (state != READY);

endmodule
